// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------+
// | uart_pkg : shared receiver state encoding and bit-period helper      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  function automatic int calc_bit_period(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// +--------------------------------------------------------------------+
// | uart_rx : 8N1 receiver with input synchronizer and byte/err strobes |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_wire_in,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  output logic       frame_err_out,
  output logic       byte_done,
  output logic [7:0] shift_data
);

  localparam int BIT_PERIOD  = calc_bit_period(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNT_W       = $clog2(BIT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PERIOD - 1);

  logic             sync_1;
  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx_wire_in;
      rx_s   <= sync_1;
    end
  end

  // Combinational view of a good stop sample so the word register updates on the same edge as byte_out.
  assign byte_done  = (state == STOP) && (baud_cnt == CNT_LAST) && rx_s;
  assign shift_data = shift;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      byte_out       <= '0;
      byte_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      byte_valid_out <= 1'b0;
      frame_err_out  <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (baud_cnt == CNT_HALF) begin
            baud_cnt <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt       <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= STOP;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              byte_out       <= shift;
              byte_valid_out <= 1'b1;
              state          <= IDLE;
            end else begin
              frame_err_out <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        // A held-low line must return high before another start is accepted.
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_word_assembler.sv
// +--------------------------------------------------------------------+
// | uart_rx_word_assembler : shifts received bytes into a 32-bit word   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx_word_assembler
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rx_wire_in,
  input  logic        clear_in,
  output logic [31:0] val_out,
  output logic [7:0]  byte_out,
  output logic        byte_valid_out,
  output logic        frame_err_out
);

  logic       byte_done;
  logic [7:0] shift_data;

  uart_rx #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_rx (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rx_wire_in    (rx_wire_in),
    .byte_out      (byte_out),
    .byte_valid_out(byte_valid_out),
    .frame_err_out (frame_err_out),
    .byte_done     (byte_done),
    .shift_data    (shift_data)
  );

  // Clear has priority over an arriving byte.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      val_out <= '0;
    end else if (clear_in) begin
      val_out <= '0;
    end else if (byte_done) begin
      val_out <= {val_out[23:0], shift_data};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_word_assembler.sv
// +--------------------------------------------------------------------+
// | tb_uart_rx_word_assembler : directed frames against a frame model   |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_word_assembler;
  import uart_pkg::*;

  localparam int CF   = 1000;
  localparam int BR   = 100;
  localparam int BIT  = 10;
  localparam int HALF = 5;
  // Pin edge to strobe: 2 sync cycles, half bit, nine full bits, one register stage.
  localparam int STROBE_OFF = 2 + HALF + 9 * BIT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] val_out;
  logic [7:0]  byte_out;
  logic        byte_valid_out;
  logic        frame_err_out;

  uart_rx_word_assembler #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rx_wire_in    (rx),
    .clear_in      (clr),
    .val_out       (val_out),
    .byte_out      (byte_out),
    .byte_valid_out(byte_valid_out),
    .frame_err_out (frame_err_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         at;
    bit         good;
    logic [7:0] b;
    bit         clr;
  } ev_t;

  ev_t         evq[$];
  logic [31:0] exp_val = '0;
  logic [7:0]  exp_byte = '0;
  int          valid_cnt = 0;
  int          err_cnt = 0;
  int          last_valid_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    ev_t  e;
    logic exp_v;
    logic exp_e;
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (evq.size() > 0 && evq[0].at == cyc) begin
      e = evq.pop_front();
      if (e.good) begin
        exp_v    = 1'b1;
        exp_byte = e.b;
        exp_val  = e.clr ? 32'h0 : {exp_val[23:0], e.b};
      end else begin
        exp_e = 1'b1;
      end
    end
    if (byte_valid_out) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (frame_err_out) err_cnt++;
    chk("byte_valid", 32'(byte_valid_out), 32'(exp_v));
    chk("frame_err", 32'(frame_err_out), 32'(exp_e));
    chk("byte_out", 32'(byte_out), 32'(exp_byte));
    chk("val_out", val_out, exp_val);
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit clr_end);
    int         n;
    logic [9:0] bits;
    ev_t        e;
    n      = cyc;
    bits   = {stop_bit, b, 1'b0};
    e.at   = n + STROBE_OFF;
    e.good = stop_bit;
    e.b    = b;
    e.clr  = clr_end;
    evq.push_back(e);
    for (int c = 0; c < 10 * BIT; c++) begin
      rx  = bits[c / BIT];
      clr = clr_end && (c == STROBE_OFF - 1);
      @(posedge clk);
      #1;
    end
    clr = 1'b0;
  endtask

  initial begin
    int         n0;
    int         vc0;
    int         ec0;
    logic [9:0] abits;

    wait_cyc(3);
    rst = 1'b0;
    chk("reset_val", val_out, 32'h0);
    chk("reset_byte", 32'(byte_out), 32'h0);
    chk("reset_state", 32'(dut.u_rx.state), 32'(IDLE));
    wait_cyc(5);

    n0 = cyc;
    send_frame(8'h41, 1'b1, 1'b0);
    wait_cyc(5);
    chk("t41_latency", 32'(last_valid_cyc - n0), 32'd98);
    chk("t41_val", val_out, 32'h0000_0041);
    chk("t41_byte", 32'(byte_out), 32'h41);

    vc0 = valid_cnt;
    send_frame(8'hDE, 1'b1, 1'b0);
    send_frame(8'hAD, 1'b1, 1'b0);
    send_frame(8'hBE, 1'b1, 1'b0);
    send_frame(8'hEF, 1'b1, 1'b0);
    wait_cyc(5);
    chk("deadbeef_val", val_out, 32'hDEAD_BEEF);
    send_frame(8'h12, 1'b1, 1'b0);
    wait_cyc(5);
    chk("wrap_val", val_out, 32'hADBE_EF12);
    chk("five_pulses", 32'(valid_cnt - vc0), 32'd5);

    vc0 = valid_cnt;
    ec0 = err_cnt;
    rx  = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(20);
    chk("false_start_val", val_out, 32'hADBE_EF12);
    chk("false_start_state", 32'(dut.u_rx.state), 32'(IDLE));
    chk("false_start_strobes", 32'((valid_cnt - vc0) + (err_cnt - ec0)), 32'd0);

    clr = 1'b1;
    wait_cyc(1);
    clr     = 1'b0;
    exp_val = 32'h0;
    wait_cyc(2);
    chk("clear_val", val_out, 32'h0);

    vc0 = valid_cnt;
    ec0 = err_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    wait_cyc(10);
    chk("hold_state", 32'(dut.u_rx.state), 32'(WAIT_HIGH));
    wait_cyc(20);
    rx = 1'b1;
    wait_cyc(10);
    chk("ferr_pulses", 32'(err_cnt - ec0), 32'd1);
    chk("ferr_no_valid", 32'(valid_cnt - vc0), 32'd0);
    chk("ferr_state", 32'(dut.u_rx.state), 32'(IDLE));
    send_frame(8'h33, 1'b1, 1'b0);
    wait_cyc(5);
    chk("after_ferr_val", val_out, 32'h0000_0033);

    vc0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cyc(5);
    chk("clr_win_val", val_out, 32'h0);
    chk("clr_win_byte", 32'(byte_out), 32'h07);
    chk("clr_win_pulse", 32'(valid_cnt - vc0), 32'd1);

    vc0   = valid_cnt;
    abits = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 35; c++) begin
      rx = abits[c / BIT];
      @(posedge clk);
      #1;
    end
    #2;
    rst      = 1'b1;
    exp_val  = 32'h0;
    exp_byte = 8'h0;
    #1;
    chk("async_rst_val", val_out, 32'h0);
    chk("async_rst_byte", 32'(byte_out), 32'h0);
    chk("async_rst_valid", 32'(byte_valid_out), 32'h0);
    chk("async_rst_ferr", 32'(frame_err_out), 32'h0);
    rx = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(5);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_cyc(5);
    chk("post_rst_val", val_out, 32'h0000_003C);
    chk("post_rst_byte", 32'(byte_out), 32'h3C);
    chk("post_rst_pulses", 32'(valid_cnt - vc0), 32'd1);
    chk("events_drained", 32'(evq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_word_assembler.md
# uart_rx_word_assembler

UART receiver and word assembler that drives the 32-bit `val_in` of the seven-segment display controller. It deserializes 8N1 frames from the board's USB-UART RX pin and shifts each good byte into a 32-bit register, newest byte in bits [7:0]. It also exposes per-byte valid and framing-error strobes for other consumers.

## Interface
Parameters:
- `CLOCK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115_200, line rate in baud.
- `BIT_PERIOD` (localparam), `CLOCK_FREQ/BAUD_RATE` (868), clock cycles per bit; `HALF_PERIOD = BIT_PERIOD/2`.

Ports:
- `clk_in` input 1: single system clock.
- `rst_in` input 1: reset, asynchronous and active-high.
- `rx_wire_in` input 1: raw asynchronous UART line, idle high.
- `clear_in` input 1: synchronous clear of `val_out`.
- `val_out` output 32: assembled word, feeds the display controller's `val_in`.
- `byte_out` output 8: last byte received without error.
- `byte_valid_out` output 1: one-cycle strobe when `byte_out` updates.
- `frame_err_out` output 1: one-cycle strobe on a bad stop bit.

## Operation
- `rx_wire_in` passes through a 2-FF synchronizer. Both flops reset to 1. All decisions use the synchronized bit `rx_s`.
- Data format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A cycle counter `baud_cnt` spans 0..BIT_PERIOD-1 and a bit index spans 0..7.
- IDLE: when `rx_s`=0, go to START with `baud_cnt`=0.
- START: at `baud_cnt`=HALF_PERIOD-1, sample `rx_s`.
  - If 1: false start, return to IDLE with no strobe.
  - If 0: go to DATA and reset `baud_cnt`.
- DATA: at each `baud_cnt`=BIT_PERIOD-1, sample into shift register bit [index]. After index 7, go to STOP.
- STOP: at `baud_cnt`=BIT_PERIOD-1, sample `rx_s`.
  - If 1: register `byte_out`<=data, pulse `byte_valid_out`, set `val_out`<={`val_out`[23:0], data}, return to IDLE.
  - If 0: pulse `frame_err_out`, discard the byte, leave `val_out` and `byte_out` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break or line-low condition from producing repeated frames.
- `clear_in` sets `val_out`<=0. If it coincides with a byte completion, the clear wins for `val_out`, and `byte_out`/`byte_valid_out` still update.
- `val_out` wraps by shifting: the oldest byte (bits [31:24]) is dropped on each good byte.

## Timing
- Reset (async assert, released synchronously by the clock): `val_out`=0, `byte_out`=0, `byte_valid_out`=0, `frame_err_out`=0, FSM=IDLE, counters=0. Asserting reset mid-frame aborts the frame immediately with no strobe.
- Pin-to-`rx_s` latency: 2 cycles. Let t0 be the first cycle with `rx_s`=0 in IDLE.
- Sample times:
  - Start bit: t0+HALF_PERIOD.
  - Data bit k: t0+HALF_PERIOD+(k+1)·BIT_PERIOD.
  - Stop bit: t0+HALF_PERIOD+9·BIT_PERIOD.
- `byte_valid_out`/`frame_err_out` are registered. They are high for exactly the one cycle after the stop sample. `val_out` and `byte_out` change on the same edge.
- Back-to-back frames: IDLE is re-entered the cycle after the stop sample, so a start edge arriving half a bit after the stop midpoint is caught.
- Strobes are never both high. At most one strobe occurs per frame.

## Structure
- Package `uart_pkg`: `rx_state_t` enum (IDLE, START, DATA, STOP, WAIT_HIGH) and a function computing BIT_PERIOD from CLOCK_FREQ/BAUD_RATE.
- Sub-module `uart_rx` contains the synchronizer, FSM, counters and byte/strobe outputs.
- The top level `uart_rx_word_assembler` adds the 32-bit shift register and `clear_in` logic.

## Test plan
All scenarios use CLOCK_FREQ=1000, BAUD_RATE=100 (BIT_PERIOD=10, HALF_PERIOD=5).
- Send frame 0x41 → single `byte_valid_out` pulse at t0+96, `byte_out`=0x41, `val_out`=0x0000_0041.
- Send 0xDE, 0xAD, 0xBE, 0xEF back-to-back → `val_out`=0xDEAD_BEEF. Then send 0x12 → `val_out`=0xADBE_EF12. Expect 5 pulses total.
- Drive `rx_wire_in` low for 3 cycles, then high → FSM returns to IDLE, no strobes, `val_out` unchanged.
- Send 0x55 with stop bit 0, hold the line low 30 cycles, release, then send 0x33 → one `frame_err_out` pulse, no `byte_valid_out` for 0x55, FSM in WAIT_HIGH during the low hold, `val_out` ends at 0x0000_0033.
- Send 0x07 with `clear_in` high on the completion cycle → `val_out`=0, `byte_out`=0x07, `byte_valid_out` pulses.
- Assert `rst_in` mid-DATA of frame 0xA5 → all outputs 0 before the next clock edge, no strobe. After release, a full 0x3C frame gives `val_out`=0x0000_003C.
